// File: rtl/seq_mult_ctrl_pkg.sv
// mult_pkg: widths and FSM state type shared by the sequential multiplier.
package mult_pkg;
  localparam int MPLR_W  = 16;
  localparam int MCAND_W = 9;
  localparam int PROD_W  = 25;
  localparam int CNT_W   = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;
endpackage

// File: rtl/seq_mult_ctrl_ppg.sv
// partial_product_generator: gates the multiplier by one multiplicand bit.
module partial_product_generator
  import mult_pkg::*;
(
  input  logic [MPLR_W-1:0] multiplier,
  input  logic              mcand_bit,
  output logic [MPLR_W-1:0] pp
);
  assign pp = mcand_bit ? multiplier : '0;
endmodule

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: 16x9 shift-add multiplier, one multiplicand bit per cycle.
module seq_mult_ctrl
  import mult_pkg::*;
#(
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MPLR_W-1:0]  multiplier,
  input  logic [MCAND_W-1:0] multiplicand,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PROD_W-1:0]  product,
  output logic               busy
);
  mult_state_t        state_q, state_d;
  logic [PROD_W-1:0]  acc_q, acc_d, acc_nx, product_q, product_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MPLR_W-1:0]  mplr_q, mplr_d, pp;
  logic [MCAND_W-1:0] mcand_q, mcand_d, rem;
  logic               in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic               busy_q, busy_d, last;

  assign rem = mcand_q >> cnt_q;

  partial_product_generator u_ppg (
    .multiplier(mplr_q),
    .mcand_bit (rem[0]),
    .pp        (pp)
  );

  assign acc_nx = acc_q + (PROD_W'(pp) << cnt_q);
  // Early exit when no set bits remain above the one just processed.
  assign last = (cnt_q == CNT_W'(MCAND_W - 1)) || (ZERO_SKIP && rem[MCAND_W-1:1] == '0);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    mplr_d      = mplr_q;
    mcand_d     = mcand_q;
    product_d   = product_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    unique case (state_q)
      IDLE: if (in_valid && in_ready_q) begin
        state_d    = RUN;
        mplr_d     = multiplier;
        mcand_d    = multiplicand;
        acc_d      = '0;
        cnt_d      = '0;
        in_ready_d = 1'b0;
        busy_d     = 1'b1;
      end
      RUN: begin
        acc_d = acc_nx;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d     = DONE;
          product_d   = acc_nx;
          out_valid_d = 1'b1;
        end
      end
      DONE: if (out_ready) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      mplr_q      <= '0;
      mcand_q     <= '0;
      product_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mplr_q      <= mplr_d;
      mcand_q     <= mcand_d;
      product_q   <= product_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// tb_seq_mult_ctrl: directed and random checks on both ZERO_SKIP variants.
module tb_seq_mult_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid[2], in_ready[2], out_valid[2], out_ready[2], busy[2];
  logic [15:0] mplr[2];
  logic [8:0]  mcand[2];
  logic [24:0] product[2];
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  seq_mult_ctrl #(.ZERO_SKIP(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .multiplier(mplr[0]), .multiplicand(mcand[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .product(product[0]), .busy(busy[0])
  );

  seq_mult_ctrl #(.ZERO_SKIP(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .multiplier(mplr[1]), .multiplicand(mcand[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .product(product[1]), .busy(busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input int z, input logic [8:0] b);
    int k = 1;
    if (z == 0) return 9;
    for (int i = 0; i < 9; i++) if (b[i]) k = i + 1;
    return k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int z, input logic [15:0] a, input logic [8:0] b);
    chk("idle_in_ready", 32'(in_ready[z]), 1);
    in_valid[z] = 1'b1;
    mplr[z]     = a;
    mcand[z]    = b;
    tick();
    in_valid[z] = 1'b0;
    mplr[z]     = ~a;
    mcand[z]    = ~b;
    chk("acc_busy", 32'(busy[z]), 1);
  endtask

  task automatic wait_done(input int z, input int el, input logic [24:0] ep);
    int n = 0;
    while (!out_valid[z] && n < 20) begin
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'(el));
    chk("product", 32'(product[z]), 32'(ep));
  endtask

  task automatic do_op(input int z, input logic [15:0] a, input logic [8:0] b,
                       input int el, input logic [24:0] ep, input int stall);
    accept(z, a, b);
    wait_done(z, el, ep);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_hold", 32'(product[z]), 32'(ep));
    end
    out_ready[z] = 1'b1;
    tick();
    out_ready[z] = 1'b0;
    chk("post_ovalid", 32'(out_valid[z]), 0);
    chk("post_iready", 32'(in_ready[z]), 1);
    chk("post_keep", 32'(product[z]), 32'(ep));
  endtask

  initial begin
    logic [15:0] a;
    logic [8:0]  b;
    for (int z = 0; z < 2; z++) begin
      in_valid[z] = 1'b0; out_ready[z] = 1'b0; mplr[z] = '0; mcand[z] = '0;
    end
    tick(); tick();
    rst = 1'b0;
    for (int z = 0; z < 2; z++) begin
      chk("rst_in_ready", 32'(in_ready[z]), 1);
      chk("rst_out_valid", 32'(out_valid[z]), 0);
      chk("rst_product", 32'(product[z]), 0);
      chk("rst_busy", 32'(busy[z]), 0);
    end

    do_op(0, 16'hFFFF, 9'h1FF, 9, 25'h1FEFE01, 0);
    do_op(1, 16'hFFFF, 9'h1FF, 9, 25'h1FEFE01, 0);
    do_op(1, 16'd3, 9'd5, 3, 25'h00000F, 1);
    do_op(1, 16'h04D2, 9'h100, 9, 25'h004D200, 0);
    do_op(1, 16'h1234, 9'h000, 1, 25'h0, 2);
    do_op(0, 16'd3, 9'd5, 9, 25'h00000F, 0);

    // Backpressure with a competing request held in DONE.
    accept(1, 16'd100, 9'd3);
    wait_done(1, 2, 25'd300);
    in_valid[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mplr[1] = 16'(i + 11); mcand[1] = 9'(i + 2);
      tick();
      chk("bp_product", 32'(product[1]), 300);
      chk("bp_in_ready", 32'(in_ready[1]), 0);
      chk("bp_out_valid", 32'(out_valid[1]), 1);
    end
    mplr[1] = 16'd21; mcand[1] = 9'd6;
    out_ready[1] = 1'b1;
    tick();
    out_ready[1] = 1'b0;
    chk("bp_release_ov", 32'(out_valid[1]), 0);
    chk("bp_release_ir", 32'(in_ready[1]), 1);
    tick();
    in_valid[1] = 1'b0;
    chk("bp_new_accept", 32'(in_ready[1]), 0);
    wait_done(1, 3, 25'd126);
    out_ready[1] = 1'b1;
    tick();
    out_ready[1] = 1'b0;

    // Abort mid-run; the next op must carry no residue.
    accept(0, 16'hABCD, 9'h1F7);
    tick(); tick(); tick();
    chk("mid_busy", 32'(busy[0]), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_out_valid", 32'(out_valid[0]), 0);
    chk("abort_product", 32'(product[0]), 0);
    chk("abort_in_ready", 32'(in_ready[0]), 1);
    chk("abort_busy", 32'(busy[0]), 0);
    do_op(0, 16'd7, 9'd9, 9, 25'd63, 0);
    do_op(1, 16'd7, 9'd9, 4, 25'd63, 0);

    for (int z = 0; z < 2; z++)
      for (int i = 0; i < 1000; i++) begin
        a = 16'($urandom_range(0, 65535));
        b = (i % 4 == 0) ? 9'($urandom_range(0, 7)) : 9'($urandom_range(0, 511));
        do_op(z, a, b, exp_lat(z, b), 25'(a) * 25'(b), int'($urandom_range(0, 3)));
      end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
